// File: rtl/movavg_decim.sv
// Averaging, decimating output stage behind the 4-tap moving-sum filter, with a show-ahead FIFO.
// Define MOVAVG_DECIM_ROUND_EN for round-half-up averaging; the default build truncates.
module movavg_decim #(
  parameter int WL    = 64,
  parameter int DECIM = 4,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     din_valid,
  input  logic [WL-1:0]            din,
  input  logic                     dout_ready,
  output logic                     dout_valid,
  output logic [WL-1:0]            dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic [PW-1:0] PHASE_LAST = PW'(DECIM - 1);
  localparam logic [AW:0]   FULL_CNT   = (AW + 1)'(DEPTH);

  logic [PW-1:0] phase;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [WL-1:0] mem [DEPTH];
  logic [WL-1:0] avg;
  logic          keep;
  logic          full;
  logic          pop;
  logic          push_ok;

`ifdef MOVAVG_DECIM_ROUND_EN
  logic [WL:0] sum_ext;
  assign sum_ext = {1'b0, din} + (WL + 1)'(2);
  assign avg     = WL'(sum_ext >> 2);
`else
  assign avg = din >> 2;
`endif

  assign keep    = din_valid && (phase == PHASE_LAST);
  assign full    = (count == FULL_CNT);
  assign pop     = dout_valid && dout_ready;
  // A full FIFO still accepts a keep sample when the head leaves in the same cycle.
  assign push_ok = keep && (!full || pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      phase    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (din_valid) begin
        if (phase == PHASE_LAST) phase <= '0;
        else                     phase <= phase + 1'b1;
      end
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (keep && full && !pop) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !reset) mem[wr_ptr] <= avg;
  end

  assign dout_valid = (count != '0);
  assign dout       = dout_valid ? mem[rd_ptr] : '0;

endmodule

// File: tb/tb_movavg_decim.sv
// Self-checking bench for movavg_decim: directed scenarios plus randomized traffic
// compared against a queue-based model of average / keep-every-Nth / bounded FIFO.
module tb_movavg_decim;
  localparam int WL    = 64;
  localparam int DECIM = 4;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          din_valid;
  logic [WL-1:0] din;
  logic          dout_ready;
  logic          dout_valid;
  logic [WL-1:0] dout;
  logic [2:0]    count;
  logic          overflow;

  int checks = 0;
  int errors = 0;

  logic [WL-1:0] q[$];
  int unsigned   nval;
  bit            ovf_m;

  movavg_decim #(.WL(WL), .DECIM(DECIM), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .din_valid(din_valid), .din(din),
    .dout_ready(dout_ready), .dout_valid(dout_valid), .dout(dout),
    .count(count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [WL-1:0] avg_of(input logic [WL-1:0] d);
    logic [WL:0] s;
`ifdef MOVAVG_DECIM_ROUND_EN
    s = ({1'b0, d} + 65'd2) / 4;
`else
    s = {1'b0, d} / 4;
`endif
    return s[WL-1:0];
  endfunction

  // Drive one cycle, advance the model across the edge, settle 1 time unit past it.
  task automatic step(input logic rst, input logic v, input logic [WL-1:0] d, input logic r);
    bit pop_m, keep_m;
    reset = rst; din_valid = v; din = d; dout_ready = r;
    @(posedge clk);
    if (rst) begin
      q.delete(); nval = 0; ovf_m = 0;
    end else begin
      pop_m  = (q.size() > 0) && r;
      keep_m = v && ((nval % DECIM) == DECIM - 1);
      if (v) nval++;
      if (pop_m) void'(q.pop_front());
      if (keep_m) begin
        if (q.size() < DEPTH) q.push_back(avg_of(d));
        else ovf_m = 1;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b1, 64'hFF, 1'b0);
      checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL reset_dout_valid got %0b want 0", dout_valid); end
      checks++; if (dout !== '0) begin errors++; $display("FAIL reset_dout got %0h want 0", dout); end
      checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d want 0", count); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %0b want 0", overflow); end
    end
  endtask

  task automatic test_stream();
    step(1'b1, 1'b0, '0, 1'b1);
    for (int k = 0; k < 24; k++) begin
      step(1'b0, 1'b1, 64'(4 * k), 1'b1);
      checks++;
      if (dout_valid !== ((k % 4) == 3)) begin errors++; $display("FAIL stream_valid k=%0d got %0b want %0b", k, dout_valid, (k % 4) == 3); end
      if ((k % 4) == 3) begin
        checks++; if (dout !== 64'(k)) begin errors++; $display("FAIL stream_dout k=%0d got %0d want %0d", k, dout, k); end
      end
      checks++; if (count > 3'd1) begin errors++; $display("FAIL stream_count k=%0d got %0d want <=1", k, count); end
    end
  endtask

  task automatic test_rounding();
    logic [WL-1:0] exp6, expmax;
`ifdef MOVAVG_DECIM_ROUND_EN
    exp6 = 64'd2; expmax = 64'h4000_0000_0000_0000;
`else
    exp6 = 64'd1; expmax = 64'h3FFF_FFFF_FFFF_FFFF;
`endif
    step(1'b1, 1'b0, '0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, '0, 1'b1);
    step(1'b0, 1'b1, 64'd6, 1'b1);
    checks++; if (dout_valid !== 1'b1 || dout !== exp6) begin errors++; $display("FAIL round_six got %0b/%0h want 1/%0h", dout_valid, dout, exp6); end
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, '0, 1'b1);
    step(1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    checks++; if (dout_valid !== 1'b1 || dout !== expmax) begin errors++; $display("FAIL round_max got %0b/%0h want 1/%0h", dout_valid, dout, expmax); end
  endtask

  task automatic test_overflow();
    step(1'b1, 1'b0, '0, 1'b0);
    for (int k = 0; k < 20; k++) begin
      step(1'b0, 1'b1, 64'(4 * k), 1'b0);
      if (k == 18) begin
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_early got %0b want 0", overflow); end
      end
    end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got %0b want 1", overflow); end
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL ovf_count got %0d want 4", count); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (dout_valid !== 1'b1 || dout !== 64'(3 + 4 * i)) begin
        errors++; $display("FAIL ovf_drain i=%0d got %0b/%0d want 1/%0d", i, dout_valid, dout, 3 + 4 * i);
      end
      step(1'b0, 1'b0, '0, 1'b1);
    end
    checks++; if (dout_valid !== 1'b0 || dout !== '0) begin errors++; $display("FAIL ovf_empty got %0b/%0h want 0/0", dout_valid, dout); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %0b want 1", overflow); end
  endtask

  task automatic test_full_pushpop();
    logic [WL-1:0] d;
    logic [WL-1:0] kept[4];
    step(1'b1, 1'b0, '0, 1'b0);
    for (int k = 0; k < 16; k++) begin
      d = {$urandom, $urandom};
      if ((k % 4) == 3) kept[k / 4] = avg_of(d);
      step(1'b0, 1'b1, d, 1'b0);
    end
    for (int k = 0; k < 3; k++) step(1'b0, 1'b1, {$urandom, $urandom}, 1'b0);
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL full_count got %0d want 4", count); end
    checks++; if (dout !== kept[0]) begin errors++; $display("FAIL full_head got %0h want %0h", dout, kept[0]); end
    step(1'b0, 1'b1, {$urandom, $urandom}, 1'b1);
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL pushpop_count got %0d want 4", count); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL pushpop_ovf got %0b want 0", overflow); end
    checks++; if (dout !== kept[1]) begin errors++; $display("FAIL pushpop_head got %0h want %0h", dout, kept[1]); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (dout_valid !== 1'b1 || dout !== q[0]) begin errors++; $display("FAIL pushpop_drain i=%0d got %0h want %0h", i, dout, q[0]); end
      step(1'b0, 1'b0, '0, 1'b1);
    end
  endtask

  task automatic test_midreset();
    step(1'b1, 1'b0, '0, 1'b0);
    for (int k = 0; k < 14; k++) step(1'b0, 1'b1, 64'(4 * k), 1'b0);
    checks++; if (count !== 3'd3) begin errors++; $display("FAIL midrst_pre got %0d want 3", count); end
    step(1'b1, 1'b1, 64'h40, 1'b0);
    checks++; if (count !== 3'd0 || dout_valid !== 1'b0) begin errors++; $display("FAIL midrst_clear got %0d/%0b want 0/0", count, dout_valid); end
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 64'(100 + 4 * i), 1'b1);
      checks++;
      if (dout_valid !== (i == 3)) begin errors++; $display("FAIL midrst_phase i=%0d got %0b want %0b", i, dout_valid, i == 3); end
    end
    checks++; if (dout !== 64'd28) begin errors++; $display("FAIL midrst_dout got %0d want 28", dout); end
  endtask

  task automatic test_random();
    logic [WL-1:0] exp_d;
    step(1'b1, 1'b0, '0, 1'b0);
    for (int i = 0; i < 500; i++) begin
      step($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0, {$urandom, $urandom}, $urandom_range(0, 2) == 0);
      exp_d = (q.size() > 0) ? q[0] : '0;
      checks++;
      if (dout_valid !== (q.size() > 0) || dout !== exp_d || count !== 3'(q.size()) || overflow !== ovf_m) begin
        errors++;
        $display("FAIL rand i=%0d got v=%0b d=%0h c=%0d o=%0b want v=%0b d=%0h c=%0d o=%0b",
                 i, dout_valid, dout, count, overflow, q.size() > 0, exp_d, q.size(), ovf_m);
      end
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_rounding();
    test_overflow();
    test_full_pushpop();
    test_midreset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
